// File: rtl/ad9361_pkg.sv
// Shared widths, FSM state encoding and constants for the AD9361 TX burst scheduler.
package ad9361_pkg;

    localparam int DW_DEF = 12;
    localparam int TW_DEF = 32;
    localparam int LW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [DW_DEF-1:0] ZERO_SAMPLE = '0;

endpackage

// File: rtl/ad9361_tx_timer.sv
// Free-running sample-time counter: advances once per TX slot, time_set loads take priority.
module ad9361_tx_timer #(
    parameter int TW = 32
) (
    input  logic          clk_out,
    input  logic          rst,
    input  logic          tx_ce,
    input  logic          time_set,
    input  logic [TW-1:0] time_val,
    output logic [TW-1:0] time_now
);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            time_now <= '0;
        end else if (time_set) begin
            time_now <= time_val;
        end else if (tx_ce) begin
            time_now <= time_now + TW'(1);
        end
    end

endmodule

// File: rtl/ad9361_tx_burst_sched.sv
// Timed TX burst scheduler: holds one pending descriptor, arms it, and streams a
// valid/ready source into the registered tx_i/tx_q outputs at the scheduled sample time.
module ad9361_tx_burst_sched
    import ad9361_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk_out,
    input  logic          rst,
    input  logic          tx_ce,
    input  logic          enable,
    input  logic          time_set,
    input  logic [TW-1:0] time_val,
    output logic [TW-1:0] time_now,
    input  logic          desc_valid,
    output logic          desc_ready,
    input  logic [TW-1:0] desc_start,
    input  logic [LW-1:0] desc_len,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_i,
    input  logic [DW-1:0] s_q,
    output logic [DW-1:0] tx_i,
    output logic [DW-1:0] tx_q,
    output logic          busy,
    output logic          late,
    output logic          underflow
);

    localparam logic [DW-1:0] ZERO = DW'(ZERO_SAMPLE);

    state_t               state;
    state_t               next_state;
    logic                 pend_full;
    logic [TW-1:0]        pend_start;
    logic [LW-1:0]        pend_len;
    logic [TW-1:0]        act_start;
    logic [LW-1:0]        rem;
    logic signed [TW-1:0] delta;
    logic                 slot;
    logic                 arm_hit;
    logic                 arm_late;
    logic                 run_slot;
    logic                 run_last;
    logic                 accept;
    logic                 load_act;

    ad9361_tx_timer #(.TW(TW)) u_timer (
        .clk_out  (clk_out),
        .rst      (rst),
        .tx_ce    (tx_ce),
        .time_set (time_set),
        .time_val (time_val),
        .time_now (time_now)
    );

    // Signed distance to the start time makes the compare wrap-safe across counter rollover.
    assign delta    = $signed(act_start - time_now);
    assign slot     = tx_ce & enable;
    assign arm_hit  = slot && (state == ARMED) && (delta == '0);
    assign arm_late = slot && (state == ARMED) && (delta < 0);
    // The ARMED slot whose compare hits zero is the first RUN slot and pops sample 0.
    assign run_slot = slot && ((state == RUN) || arm_hit);
    assign run_last = run_slot && (rem == LW'(1));

    assign desc_ready = ~pend_full & enable;
    assign accept     = desc_valid & desc_ready & (desc_len != '0);
    assign load_act   = enable & pend_full & ((state == IDLE) | run_last);
    assign s_ready    = run_slot;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_full) next_state = ARMED;
                end
                ARMED, RUN: begin
                    if (arm_late) begin
                        next_state = IDLE;
                    end else if (run_last) begin
                        next_state = pend_full ? ARMED : IDLE;
                    end else if (arm_hit) begin
                        next_state = RUN;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            pend_full  <= 1'b0;
            pend_start <= '0;
            pend_len   <= '0;
            act_start  <= '0;
            rem        <= '0;
            tx_i       <= ZERO;
            tx_q       <= ZERO;
            late       <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            late      <= arm_late;
            underflow <= run_slot & ~s_valid;

            if (!enable) begin
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_full  <= 1'b1;
                pend_start <= desc_start;
                pend_len   <= desc_len;
            end else if (load_act) begin
                pend_full <= 1'b0;
            end

            if (load_act) begin
                act_start <= pend_start;
                rem       <= pend_len;
            end else if (run_slot) begin
                rem <= rem - LW'(1);
            end

            // Outputs only move on slot cycles so they stay stable for the interface capture.
            if (!enable) begin
                tx_i <= ZERO;
                tx_q <= ZERO;
            end else if (tx_ce) begin
                tx_i <= (run_slot && s_valid) ? s_i : ZERO;
                tx_q <= (run_slot && s_valid) ? s_q : ZERO;
            end
        end
    end

endmodule
